mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 32 +++
 rtl/mem_port_arbiter.sv | 71 +++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes and shared memory port of the arbiter
interface mem_port_arbiter_if #(parameter int ADDR = 32, parameter int WORD = 32);
   logic            ld_req_i;
   logic [ADDR-1:0] ld_addr_i;
   logic [WORD-1:0] ld_data_i;
   logic            ld_ack_o;
   logic            d_req_i;
   logic            d_we_i;
   logic [ADDR-1:0] d_addr_i;
   logic [WORD-1:0] d_data_i;
   logic            d_ack_o;
   logic            d_rvalid_o;
   logic [WORD-1:0] d_rdata_o;
   logic            i_req_i;
   logic [ADDR-1:0] i_addr_i;
   logic            i_ack_o;
   logic            i_rvalid_o;
   logic [WORD-1:0] i_rdata_o;
   logic [ADDR-1:0] mem_a_o;
   logic            mem_w_o;
   logic [WORD-1:0] mem_d_o;
   logic [WORD-1:0] mem_q_i;
   logic            stall_o;
   modport slave (
      input  ld_req_i, ld_addr_i, ld_data_i, d_req_i, d_we_i, d_addr_i, d_data_i, i_req_i, i_addr_i, mem_q_i,
      output ld_ack_o, d_ack_o, d_rvalid_o, d_rdata_o, i_ack_o, i_rvalid_o, i_rdata_o, mem_a_o, mem_w_o, mem_d_o, stall_o
   );
   modport master (
      output ld_req_i, ld_addr_i, ld_data_i, d_req_i, d_we_i, d_addr_i, d_data_i, i_req_i, i_addr_i, mem_q_i,
      input  ld_ack_o, d_ack_o, d_rvalid_o, d_rdata_o, i_ack_o, i_rvalid_o, i_rdata_o, mem_a_o, mem_w_o, mem_d_o, stall_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: loader/data/fetch arbiter for one single-port memory, loader first.
// Defining MEM_ARB_RR_EN makes data and fetch alternate on conflict instead of data winning.
module mem_port_arbiter #(
   parameter int ADDR = 32,
   parameter int WORD = 32
) (
   input logic clk,
   input logic reset,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic {RUN, LOAD} state_t;
   state_t state, state_n;
   logic gnt_l, gnt_d, gnt_i, pend_d, pend_i;
   logic [ADDR-1:0] a;
   logic [WORD-1:0] wd;
`ifdef MEM_ARB_RR_EN
   logic prefer_d;
`endif
   always_comb begin
      state_n = state;
      gnt_l = 1'b0;
      gnt_d = 1'b0;
      gnt_i = 1'b0;
      if (!reset) begin
         if (bus.ld_req_i) begin
            gnt_l = 1'b1;
            state_n = LOAD;
         end else if (state == LOAD) begin
            // exit cycle: memory stays idle, d/i arbitrate again next cycle
            state_n = RUN;
         end else begin
`ifdef MEM_ARB_RR_EN
            gnt_d = bus.d_req_i && (prefer_d || !bus.i_req_i);
`else
            gnt_d = bus.d_req_i;
`endif
            gnt_i = bus.i_req_i && !gnt_d;
         end
      end
   end
   assign a  = gnt_l ? bus.ld_addr_i : gnt_d ? bus.d_addr_i : gnt_i ? bus.i_addr_i : '0;
   assign wd = gnt_l ? bus.ld_data_i : gnt_d ? bus.d_data_i : '0;
   assign bus.mem_a_o    = a;
   assign bus.mem_d_o    = wd;
   assign bus.mem_w_o    = gnt_l || (gnt_d && bus.d_we_i);
   assign bus.ld_ack_o   = gnt_l;
   assign bus.d_ack_o    = gnt_d;
   assign bus.i_ack_o    = gnt_i;
   assign bus.stall_o    = !reset && (state == LOAD || bus.ld_req_i);
   assign bus.d_rvalid_o = pend_d && !reset;
   assign bus.i_rvalid_o = pend_i && !reset;
   assign bus.d_rdata_o  = bus.d_rvalid_o ? bus.mem_q_i : '0;
   assign bus.i_rdata_o  = bus.i_rvalid_o ? bus.mem_q_i : '0;
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= RUN;
         pend_d <= 1'b0;
         pend_i <= 1'b0;
      end else begin
         state  <= state_n;
         pend_d <= gnt_d && !bus.d_we_i;
         pend_i <= gnt_i;
      end
   end
`ifdef MEM_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (reset) prefer_d <= 1'b1;
      else if (gnt_d || gnt_i) prefer_d <= gnt_i;
   end
`endif
endmodule
